// File: rtl/stopwatch_sequencer_if.sv
// Button/tick inputs and display outputs of the stopwatch sequencer.
// master = stimulus side, slave = sequencer side.
interface stopwatch_sequencer_if;
   logic        start_stop;
   logic        lap_clear;
   logic        tick;
   logic        count_down;
   logic [15:0] preset;
   logic [15:0] disp;
   logic        running;
   logic        lap_active;
   logic        expired;

   modport master (
      output start_stop, lap_clear, tick, count_down, preset,
      input  disp, running, lap_active, expired
   );

   modport slave (
      input  start_stop, lap_clear, tick, count_down, preset,
      output disp, running, lap_active, expired
   );
endinterface

// File: rtl/stopwatch_sequencer.sv
// Stopwatch/timer control FSM with an MM:SS BCD counter and a lap freeze register.
// disp shows the frozen lap value in LAP, otherwise the live counter.
module stopwatch_sequencer #(
   parameter int MIN_TENS_MAX = 5,
   parameter bit WRAP         = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   stopwatch_sequencer_if.slave sw
);

   localparam logic [3:0]  M10_MAX = 4'(MIN_TENS_MAX);
   localparam logic [15:0] FULL    = {M10_MAX, 4'd9, 4'd5, 4'd9};

   typedef enum logic [2:0] {IDLE, RUN, LAP, PAUSE, EXPIRED} state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [15:0] lap_reg;
   logic        dir;
   logic [15:0] cnt_step;
   logic        preset_ok;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v == FULL)
         r = WRAP ? 16'h0000 : FULL;
      else if (v[3:0] != 4'd9)
         r[3:0] = v[3:0] + 4'd1;
      else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd5)
            r[7:4] = v[7:4] + 4'd1;
         else begin
            r[7:4] = 4'd0;
            if (v[11:8] != 4'd9)
               r[11:8] = v[11:8] + 4'd1;
            else begin
               r[11:8]  = 4'd0;
               r[15:12] = v[15:12] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   // 0000 never steps down in practice (it expires first); keep it pinned anyway.
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v == 16'h0000)
         r = 16'h0000;
      else if (v[3:0] != 4'd0)
         r[3:0] = v[3:0] - 4'd1;
      else begin
         r[3:0] = 4'd9;
         if (v[7:4] != 4'd0)
            r[7:4] = v[7:4] - 4'd1;
         else begin
            r[7:4] = 4'd5;
            if (v[11:8] != 4'd0)
               r[11:8] = v[11:8] - 4'd1;
            else begin
               r[11:8]  = 4'd9;
               r[15:12] = v[15:12] - 4'd1;
            end
         end
      end
      return r;
   endfunction

   assign cnt_step  = dir ? bcd_dec(cnt) : bcd_inc(cnt);
   assign preset_ok = (sw.preset != 16'h0000) && (sw.preset[3:0] <= 4'd9) &&
                      (sw.preset[7:4] <= 4'd5) && (sw.preset[11:8] <= 4'd9) &&
                      (sw.preset[15:12] <= M10_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 16'h0000;
         lap_reg <= 16'h0000;
         dir     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= sw.count_down ? sw.preset : 16'h0000;
               if (sw.start_stop && (!sw.count_down || preset_ok)) begin
                  dir   <= sw.count_down;
                  state <= RUN;
               end
            end
            RUN, LAP: begin
               if (sw.tick)
                  cnt <= cnt_step;
               // Reaching zero on a down count wins over any same-cycle button.
               if (sw.tick && dir && cnt == 16'h0001)
                  state <= EXPIRED;
               else if (sw.start_stop)
                  state <= PAUSE;
               else if (sw.lap_clear) begin
                  if (state == RUN) begin
                     lap_reg <= cnt;
                     state   <= LAP;
                  end else
                     state <= RUN;
               end
            end
            PAUSE: begin
               if (sw.start_stop)
                  state <= RUN;
               else if (sw.lap_clear)
                  state <= IDLE;
            end
            EXPIRED: begin
               cnt <= 16'h0000;
               if (sw.start_stop || sw.lap_clear)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sw.disp       = (state == LAP) ? lap_reg : cnt;
   assign sw.running    = (state == RUN) || (state == LAP);
   assign sw.lap_active = (state == LAP);
   assign sw.expired    = (state == EXPIRED);

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Drives a wrapping and a saturating sequencer with identical stimulus and compares
// both against a seconds-based reference model.
module tb_stopwatch_sequencer;

   localparam int FULL_S = 59 * 60 + 59;

   logic        clk = 1'b0;
   logic        rst_v = 1'b1;
   logic        ss = 1'b0, lc = 1'b0, tk = 1'b0, cd = 1'b0;
   logic [15:0] pre = 16'h0000;

   int checks = 0;
   int errors = 0;

   stopwatch_sequencer_if sif0 ();
   stopwatch_sequencer_if sif1 ();

   assign sif0.start_stop = ss;  assign sif1.start_stop = ss;
   assign sif0.lap_clear  = lc;  assign sif1.lap_clear  = lc;
   assign sif0.tick       = tk;  assign sif1.tick       = tk;
   assign sif0.count_down = cd;  assign sif1.count_down = cd;
   assign sif0.preset     = pre; assign sif1.preset     = pre;

   stopwatch_sequencer #(.MIN_TENS_MAX(5), .WRAP(1'b0)) dut_sat  (.clk(clk), .rst(rst_v), .sw(sif0.slave));
   stopwatch_sequencer #(.MIN_TENS_MAX(5), .WRAP(1'b1)) dut_wrap (.clk(clk), .rst(rst_v), .sw(sif1.slave));

   always #5 clk = ~clk;

   // Model state: 0 idle, 1 run, 2 lap, 3 pause, 4 expired. Index 0 saturates, 1 wraps.
   int          mst  [2];
   logic [15:0] mcnt [2];
   logic [15:0] mlap [2];
   bit          mdir [2];

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int to_sec(input logic [15:0] b);
      return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [15:0] to_bcd(input int s);
      int m, x;
      m = s / 60;
      x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   function automatic bit preset_valid(input logic [15:0] p);
      return p != 16'h0000 && p[3:0] <= 4'd9 && p[7:4] <= 4'd5 &&
             p[11:8] <= 4'd9 && p[15:12] <= 4'd5;
   endfunction

   task automatic model_step(input int k);
      int          s;
      bit          expire;
      logic [15:0] old;
      if (rst_v) begin
         mst[k] = 0; mcnt[k] = 16'h0; mlap[k] = 16'h0; mdir[k] = 1'b0;
         return;
      end
      case (mst[k])
         0: begin
            mcnt[k] = cd ? pre : 16'h0000;
            if (ss && (!cd || preset_valid(pre))) begin
               mdir[k] = cd;
               mst[k]  = 1;
            end
         end
         1, 2: begin
            old    = mcnt[k];
            s      = to_sec(mcnt[k]);
            expire = 1'b0;
            if (tk) begin
               if (mdir[k]) begin
                  s = s - 1;
                  expire = (s == 0);
               end else begin
                  s = s + 1;
                  if (s > FULL_S) s = (k == 1) ? 0 : FULL_S;
               end
               mcnt[k] = to_bcd(s);
            end
            if (expire) mst[k] = 4;
            else if (ss) mst[k] = 3;
            else if (lc) begin
               if (mst[k] == 1) begin
                  mlap[k] = old;
                  mst[k]  = 2;
               end else
                  mst[k] = 1;
            end
         end
         3: begin
            if (ss) mst[k] = 1;
            else if (lc) mst[k] = 0;
         end
         default: begin
            mcnt[k] = 16'h0000;
            if (ss || lc) mst[k] = 0;
         end
      endcase
   endtask

   task automatic chk_all();
      chk("sat disp",    sif0.disp,             (mst[0] == 2) ? mlap[0] : mcnt[0]);
      chk("sat running", 16'(sif0.running),     16'(mst[0] == 1 || mst[0] == 2));
      chk("sat lap",     16'(sif0.lap_active),  16'(mst[0] == 2));
      chk("sat expired", 16'(sif0.expired),     16'(mst[0] == 4));
      chk("wrap disp",   sif1.disp,             (mst[1] == 2) ? mlap[1] : mcnt[1]);
      chk("wrap running",16'(sif1.running),     16'(mst[1] == 1 || mst[1] == 2));
      chk("wrap lap",    16'(sif1.lap_active),  16'(mst[1] == 2));
      chk("wrap expired",16'(sif1.expired),     16'(mst[1] == 4));
   endtask

   task automatic cyc(input bit s, input bit l, input bit t);
      ss = s; lc = l; tk = t;
      @(posedge clk);
      #1;
      model_step(0);
      model_step(1);
      ss = 1'b0; lc = 1'b0; tk = 1'b0;
      chk_all();
   endtask

   initial begin
      logic [15:0] plist [6];
      plist[0] = 16'h0000; plist[1] = 16'h0003; plist[2] = 16'h0100;
      plist[3] = 16'h0070; plist[4] = 16'h0012; plist[5] = 16'h0000;
      for (int k = 0; k < 2; k++) begin
         mst[k] = 0; mcnt[k] = 16'h0; mlap[k] = 16'h0; mdir[k] = 1'b0;
      end

      rst_v = 1'b1;
      cyc(0, 0, 0);
      rst_v = 1'b0;
      chk("reset disp", sif1.disp, 16'h0000);
      chk("reset running", 16'(sif1.running), 16'h0);

      // Count up 61 s.
      cyc(1, 0, 0);
      repeat (61) cyc(0, 0, 1);
      chk("t1 disp", sif1.disp, 16'h0101);
      chk("t1 running", 16'(sif1.running), 16'h1);

      // Lap freeze while counting continues, then back to live display.
      cyc(0, 1, 0);
      repeat (5) cyc(0, 0, 1);
      chk("lap frozen", sif1.disp, 16'h0101);
      chk("lap active", 16'(sif1.lap_active), 16'h1);
      cyc(0, 1, 0);
      chk("lap release", sif1.disp, 16'h0106);

      // start_stop beats lap_clear; tick+start_stop still counts.
      cyc(1, 1, 0);
      chk("prio pause", 16'(sif1.running), 16'h0);
      cyc(1, 0, 0);
      cyc(1, 0, 1);
      chk("tick+stop disp", sif1.disp, 16'h0107);
      chk("tick+stop run", 16'(sif1.running), 16'h0);
      cyc(1, 0, 1);
      chk("pause tick ign", sif1.disp, 16'h0107);

      // Full scale: wrap vs saturate.
      repeat (FULL_S - to_sec(16'h0107)) cyc(0, 0, 1);
      chk("full scale", sif1.disp, 16'h5959);
      cyc(0, 0, 1);
      chk("wrap 0000", sif1.disp, 16'h0000);
      chk("sat 5959", sif0.disp, 16'h5959);
      chk("sat running", 16'(sif0.running), 16'h1);
      cyc(1, 0, 0);
      cyc(0, 1, 0);

      // Count-down timer to expiry, then back to IDLE showing the preset.
      cd = 1'b1; pre = 16'h0100;
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      repeat (60) cyc(0, 0, 1);
      chk("expired disp", sif1.disp, 16'h0000);
      chk("expired flag", 16'(sif1.expired), 16'h1);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      chk("idle preset", sif1.disp, 16'h0100);
      chk("idle expired", 16'(sif1.expired), 16'h0);

      // Invalid and zero presets refuse to start.
      pre = 16'h0070;
      cyc(1, 0, 0);
      chk("bad preset", 16'(sif1.running), 16'h0);
      pre = 16'h0000;
      cyc(1, 0, 0);
      chk("zero preset", 16'(sif1.running), 16'h0);

      // Reset mid-run.
      cd = 1'b0;
      cyc(1, 0, 0);
      cyc(0, 0, 1);
      rst_v = 1'b1;
      cyc(1, 1, 1);
      rst_v = 1'b0;
      chk("rst disp", sif1.disp, 16'h0000);
      chk("rst running", 16'(sif1.running), 16'h0);

      // Random soak.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(49) == 0) cd = 1'($urandom_range(1));
         if ($urandom_range(29) == 0) begin
            if ($urandom_range(3) == 0) pre = 16'($urandom) & 16'h5f5f;
            else pre = plist[$urandom_range(5)];
         end
         rst_v = ($urandom_range(499) == 0);
         cyc($urandom_range(15) == 0, $urandom_range(11) == 0, $urandom_range(2) == 0);
         rst_v = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
